vend_ctrl_multi: RTL and testbench
==================================

# vend_ctrl_multi

Parametrised multi-product vending controller: accepts two coin denominations into a bounded credit register, vends one of N_PROD products per selection through a valid/ack handshake, and returns change coin-by-coin through a second handshake. It sits between the coin acceptor/button front end and the dispenser/coin-hopper drivers, and adds per-product pricing, overflow rejection and handshaked dispensing to the previous single-product, fixed-price controller.

## Interface
- N_PROD, 4, number of products, at least 1
- CREDIT_W, 5, credit width in coin units
- MAX_CREDIT, 20, upper credit bound, at most 2^CREDIT_W-1
- COIN_LO_VAL, 1, small coin value
- COIN_HI_VAL, 5, large coin value; must be a multiple of COIN_LO_VAL
- CNT_W, 3, width of the vend counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coin_valid  in  1  coin inserted this cycle
- coin_hi  in  1  1 = large coin, 0 = small coin
- sel_valid  in  1  product selection pulse
- sel_id  in  $clog2(N_PROD) (min 1)  selected product
- refund_req  in  1  change/refund button pulse
- price  in  N_PROD*CREDIT_W  flattened per-product prices; product k is at bits [k*CREDIT_W +: CREDIT_W]
- credit  out  CREDIT_W  current credit
- can_buy  out  N_PROD  bit k = credit >= price[k], evaluated in CREDIT state only
- coin_reject  out  1  one-cycle pulse: coin was not accepted
- vend_valid  out  1  dispense request
- vend_id  out  $clog2(N_PROD)  product being dispensed
- vend_ack  in  1  dispenser accepted the request
- chg_valid  out  1  change coin request
- chg_hi  out  1  coin type of the change request
- chg_ready  in  1  hopper accepted the coin
- vend_count  out  CNT_W  products vended in the current session, saturating

## Operation
- States are IDLE, CREDIT, VEND and CHANGE. All outputs are registered.
- IDLE: credit is 0. An accepted coin moves the FSM to CREDIT. sel_valid and refund_req are ignored.
- CREDIT:
  - Priority is refund_req > sel_valid > coin_valid.
  - refund_req goes to CHANGE; if credit is 0, it goes directly to IDLE.
  - sel_valid with price[sel_id] <= credit and price nonzero: debit the price, latch vend_id, go to VEND.
  - sel_valid with insufficient credit: ignored and the FSM stays in CREDIT. An out-of-range sel_id is also ignored.
- Coin acceptance: a coin is accepted only in IDLE or CREDIT, only when no higher-priority event occurs that cycle, and only if credit + value <= MAX_CREDIT. Every other coin_valid produces coin_reject.
- VEND: hold vend_valid and vend_id stable until vend_ack. On ack, increment vend_count (saturating) and return to CREDIT. Coins and selections are rejected or ignored in this state.
- CHANGE: greedy dispensing. chg_hi = (credit >= COIN_HI_VAL). chg_valid is held until chg_ready; each handshake subtracts the coin's value from credit. When credit < COIN_LO_VAL, any nonzero remainder is cleared and the FSM goes to IDLE; vend_count clears on that transition.
- Credit arithmetic uses CREDIT_W+1 bits internally, so overflow cannot wrap.

## Timing
- Reset values: FSM in IDLE, credit 0, can_buy 0, coin_reject 0, vend_valid 0, vend_id 0, chg_valid 0, chg_hi 0, vend_count 0.
- A coin accepted at edge N is visible on credit after edge N. coin_reject is high for exactly the cycle after the offending edge.
- Selection accepted at edge N: the debited credit and vend_valid are both visible after edge N.
- vend_ack sampled high at edge M: vend_valid is low after edge M. Back-to-back vends are therefore at least 2 cycles apart.
- Change coins: one per cycle at best, when chg_ready is held high.
- can_buy lags credit by 0 cycles because it is registered from next-credit.
- Reset asserted mid-VEND or mid-CHANGE aborts immediately. The outstanding request is dropped and the credit is lost.

## Configuration
- VEND_AUTO_CHANGE_EN defined: single-purchase mode. After vend_ack the FSM goes to CHANGE instead of CREDIT, and any remaining credit is refunded automatically.
- VEND_AUTO_CHANGE_EN undefined: credit persists after a vend, multiple purchases per session are allowed, and change is returned only on refund_req.

## Structure
- Shared package vend_pkg holds:
  - the state enum (IDLE/CREDIT/VEND/CHANGE)
  - localparams for default coin values
  - a function packing and unpacking the flattened price bus
- One sub-module, vend_change_disp, contains the greedy coin selector and the chg_valid/chg_ready handshake. Inputs: start, credit. Outputs: coin decrement, done.

## Test plan
- Defaults, prices {3,5,7,10}: insert lo, lo, hi → credit 7; can_buy = 4'b0111; vend_count 0.
- Credit 18, insert hi → coin_reject pulse, credit stays 18. Insert lo → credit 19.
- Credit 7, select product 1 (price 5) → vend_valid, vend_id 1, credit 2. Hold vend_ack low 3 cycles → request stays stable. Ack → vend_count 1.
- Credit 12, refund_req with chg_ready toggling → chg sequence hi, hi, lo, lo. Credit ends at 0, then IDLE, vend_count 0.
- Same cycle coin_valid + sel_valid at credit 5, product 0 → vend proceeds, coin_reject pulse, credit 2.
- VEND_AUTO_CHANGE_EN: credit 9, buy product 0 → after ack, change of hi, lo; reset asserted mid-change → all outputs 0 next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and helpers for the multi-product vending
//               controller: FSM state encoding, default coin values and
//               pack/unpack helpers for the flattened per-product price bus.
//               Contents:
//                 vend_state_t  - IDLE / CREDIT / VEND / CHANGE
//                 c_COIN_*_DEF  - default coin values in coin units
//                 price_unpack  - extract product idx from a price bus
//                 price_pack    - insert product idx into a price bus
// Revision    : 1.0 - initial multi-product release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_t;

    localparam int c_COIN_LO_DEF  = 1;
    localparam int c_COIN_HI_DEF  = 5;

    // Helpers work on a fixed-width container so they can serve any
    // N_PROD x CREDIT_W combination that fits inside it.
    localparam int c_PRICE_BUS_W  = 256;
    localparam int c_PRICE_IDX_W  = 8;
    localparam int c_PRICE_W_MAX  = 16;

    typedef logic [c_PRICE_BUS_W-1:0] price_bus_t;
    typedef logic [c_PRICE_W_MAX-1:0] price_t;

    // Returns the w-bit price of product idx, zero-extended.
    function automatic price_t price_unpack(input price_bus_t bus, input int idx, input int w);
        price_t r;
        int     pos;
        r = '0;
        for (int b = 0; b < c_PRICE_W_MAX; b++) begin
            pos = idx * w + b;
            if (b < w && pos >= 0 && pos < c_PRICE_BUS_W) begin
                r[b] = bus[pos[c_PRICE_IDX_W-1:0]];
            end
        end
        return r;
    endfunction

    // Returns bus with the w-bit field of product idx replaced by val.
    function automatic price_bus_t price_pack(input price_bus_t bus, input int idx, input int w,
                                              input price_t val);
        price_bus_t r;
        int         pos;
        r = bus;
        for (int b = 0; b < c_PRICE_W_MAX; b++) begin
            pos = idx * w + b;
            if (b < w && pos >= 0 && pos < c_PRICE_BUS_W) begin
                r[pos[c_PRICE_IDX_W-1:0]] = val[b];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_disp.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_disp
// Description : Greedy change-coin selector with chg_valid/chg_ready
//               handshake. Large coins are paid while credit covers them,
//               then small coins.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               start           - the controller will be in CHANGE next cycle
//               credit          - credit as it will stand next cycle
//               chg_ready       - hopper accepted the current coin
//               chg_valid/hi    - registered change-coin request and type
//               coin_dec        - value paid out by this cycle's handshake
//               done            - credit can no longer pay a small coin
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_disp #(
    parameter int CREDIT_W    = 5,
    parameter int COIN_LO_VAL = 1,
    parameter int COIN_HI_VAL = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CREDIT_W:0] credit,
    input  logic              chg_ready,
    output logic              chg_valid,
    output logic              chg_hi,
    output logic [CREDIT_W:0] coin_dec,
    output logic              done
);
    localparam int                c_EXT_W = CREDIT_W + 1;
    localparam logic [c_EXT_W-1:0] c_LO   = c_EXT_W'(COIN_LO_VAL);
    localparam logic [c_EXT_W-1:0] c_HI   = c_EXT_W'(COIN_HI_VAL);

    logic r_chg_valid;
    logic r_chg_hi;

    assign done     = (credit < c_LO);
    assign coin_dec = (r_chg_valid && chg_ready) ? (r_chg_hi ? c_HI : c_LO) : '0;

    // The request for next cycle is computed from the post-handshake credit,
    // so a held chg_ready yields one coin per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chg_valid <= 1'b0;
            r_chg_hi    <= 1'b0;
        end else begin
            r_chg_valid <= start && !done;
            r_chg_hi    <= start && !done && (credit >= c_HI);
        end
    end

    assign chg_valid = r_chg_valid;
    assign chg_hi    = r_chg_hi;

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_multi
// Description : Multi-product vending controller. Two coin values feed a
//               bounded credit register; selections debit a per-product
//               price and dispense via vend_valid/vend_ack; change is
//               returned coin-by-coin via chg_valid/chg_ready.
// Ports       : clk, reset (async, active-high)
//               coin_valid/coin_hi, sel_valid/sel_id, refund_req, price
//               credit, can_buy, coin_reject, vend_valid/vend_id/vend_ack,
//               chg_valid/chg_hi/chg_ready, vend_count
// Config      : VEND_AUTO_CHANGE_EN - defined: refund remaining credit
//               automatically after each vend (single purchase per session).
//               Undefined: credit persists until refund_req.
// Revision    : 1.0 - initial multi-product release
// ============================================================================
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int  N_PROD      = 4,
    parameter int  CREDIT_W    = 5,
    parameter int  MAX_CREDIT  = 20,
    parameter int  COIN_LO_VAL = c_COIN_LO_DEF,
    parameter int  COIN_HI_VAL = c_COIN_HI_DEF,
    parameter int  CNT_W       = 3,
    localparam int c_SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       coin_valid,
    input  logic                       coin_hi,
    input  logic                       sel_valid,
    input  logic [c_SEL_W-1:0]         sel_id,
    input  logic                       refund_req,
    input  logic [N_PROD*CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0]        credit,
    output logic [N_PROD-1:0]          can_buy,
    output logic                       coin_reject,
    output logic                       vend_valid,
    output logic [c_SEL_W-1:0]         vend_id,
    input  logic                       vend_ack,
    output logic                       chg_valid,
    output logic                       chg_hi,
    input  logic                       chg_ready,
    output logic [CNT_W-1:0]           vend_count
);
    localparam int                 c_EXT_W   = CREDIT_W + 1;
    localparam logic [c_EXT_W-1:0] c_LO      = c_EXT_W'(COIN_LO_VAL);
    localparam logic [c_EXT_W-1:0] c_HI      = c_EXT_W'(COIN_HI_VAL);
    localparam logic [c_EXT_W-1:0] c_MAX     = c_EXT_W'(MAX_CREDIT);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

    vend_state_t         r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [N_PROD-1:0]   r_can_buy, w_can_buy_nxt;
    logic                r_coin_reject;
    logic                r_vend_valid;
    logic [c_SEL_W-1:0]  r_vend_id;
    logic [CNT_W-1:0]    r_vend_count;

    price_bus_t          w_price_bus;
    price_t              w_sel_price;
    logic [c_EXT_W-1:0]  w_credit_ext, w_coin_val, w_coin_sum;
    logic [c_EXT_W-1:0]  w_credit_after_chg, w_chg_dec;
    logic                w_sel_ok, w_coin_ok, w_chg_done, w_chg_start;

    assign w_price_bus  = price_bus_t'(price);
    assign w_sel_price  = price_unpack(w_price_bus, int'(sel_id), CREDIT_W);
    assign w_credit_ext = {1'b0, r_credit};
    assign w_coin_val   = coin_hi ? c_HI : c_LO;
    assign w_coin_sum   = w_credit_ext + w_coin_val;

    // Zero-priced or out-of-range products can never be selected.
    assign w_sel_ok = (r_state == ST_CREDIT) && sel_valid && !refund_req &&
                      (int'(sel_id) < N_PROD) && (w_sel_price != '0) &&
                      (w_sel_price <= price_t'(r_credit));

    // An ignored (unaffordable) selection does not block a coin.
    assign w_coin_ok = coin_valid && (w_coin_sum <= c_MAX) &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_CREDIT) && !refund_req && !w_sel_ok));

    // w_chg_dec is nonzero only during a CHANGE handshake.
    assign w_credit_after_chg = w_credit_ext - w_chg_dec;
    assign w_chg_start        = (w_state_nxt == ST_CHANGE);

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_ok) begin
                    w_state_nxt  = ST_CREDIT;
                    w_credit_nxt = CREDIT_W'(w_coin_sum);
                end
            end
            ST_CREDIT: begin
                if (refund_req) begin
                    if (w_chg_done) begin
                        w_state_nxt  = ST_IDLE;
                        w_credit_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_CHANGE;
                    end
                end else if (w_sel_ok) begin
                    w_state_nxt  = ST_VEND;
                    w_credit_nxt = CREDIT_W'(price_t'(r_credit) - w_sel_price);
                end else if (w_coin_ok) begin
                    w_credit_nxt = CREDIT_W'(w_coin_sum);
                end
            end
            ST_VEND: begin
                if (vend_ack) begin
`ifdef VEND_AUTO_CHANGE_EN
                    w_state_nxt = ST_CHANGE;
`else
                    w_state_nxt = ST_CREDIT;
`endif
                end
            end
            ST_CHANGE: begin
                if (w_chg_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_credit_nxt = '0;
                end else begin
                    w_credit_nxt = CREDIT_W'(w_credit_after_chg);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    // can_buy is registered from next-state credit so it tracks credit
    // without an extra cycle of lag.
    generate
        for (genvar k = 0; k < N_PROD; k++) begin : g_can_buy
            assign w_can_buy_nxt[k] = (w_state_nxt == ST_CREDIT) &&
                (price_t'(w_credit_nxt) >= price_unpack(w_price_bus, k, CREDIT_W));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_can_buy     <= '0;
            r_coin_reject <= 1'b0;
            r_vend_valid  <= 1'b0;
            r_vend_id     <= '0;
            r_vend_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_can_buy     <= w_can_buy_nxt;
            r_coin_reject <= coin_valid && !w_coin_ok;
            r_vend_valid  <= (w_state_nxt == ST_VEND);
            if (w_sel_ok) begin
                r_vend_id <= sel_id;
            end
            // Returning to IDLE ends the session.
            if (w_state_nxt == ST_IDLE) begin
                r_vend_count <= '0;
            end else if ((r_state == ST_VEND) && vend_ack && (r_vend_count != c_CNT_MAX)) begin
                r_vend_count <= r_vend_count + CNT_W'(1);
            end
        end
    end

    vend_change_disp #(
        .CREDIT_W    (CREDIT_W),
        .COIN_LO_VAL (COIN_LO_VAL),
        .COIN_HI_VAL (COIN_HI_VAL)
    ) u_change_disp (
        .clk       (clk),
        .reset     (reset),
        .start     (w_chg_start),
        .credit    (w_credit_after_chg),
        .chg_ready (chg_ready),
        .chg_valid (chg_valid),
        .chg_hi    (chg_hi),
        .coin_dec  (w_chg_dec),
        .done      (w_chg_done)
    );

    assign credit      = r_credit;
    assign can_buy     = r_can_buy;
    assign coin_reject = r_coin_reject;
    assign vend_valid  = r_vend_valid;
    assign vend_id     = r_vend_id;
    assign vend_count  = r_vend_count;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl_multi
// Description : Self-checking bench for vend_ctrl_multi with default
//               parameters and prices {3,5,7,10}. Expected change coins and
//               vend ids are queued when stimulus is driven and compared
//               when the DUT hands them out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_multi;
    import vend_pkg::*;

    localparam int N_PROD   = 4;
    localparam int CREDIT_W = 5;
    localparam int CNT_W    = 3;
    localparam int SEL_W    = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       coin_valid, coin_hi, sel_valid, refund_req;
    logic                       vend_ack, chg_ready;
    logic [SEL_W-1:0]           sel_id;
    logic [N_PROD*CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0]        credit;
    logic [N_PROD-1:0]          can_buy;
    logic                       coin_reject, vend_valid, chg_valid, chg_hi;
    logic [SEL_W-1:0]           vend_id;
    logic [CNT_W-1:0]           vend_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic             exp_chg_q[$];
    logic [SEL_W-1:0] exp_vend_q[$];

    always #5 clk = ~clk;

    vend_ctrl_multi dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_hi     (coin_hi),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .refund_req  (refund_req),
        .price       (price),
        .credit      (credit),
        .can_buy     (can_buy),
        .coin_reject (coin_reject),
        .vend_valid  (vend_valid),
        .vend_id     (vend_id),
        .vend_ack    (vend_ack),
        .chg_valid   (chg_valid),
        .chg_hi      (chg_hi),
        .chg_ready   (chg_ready),
        .vend_count  (vend_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input logic hi);
        coin_valid = 1'b1;
        coin_hi    = hi;
        step();
        coin_valid = 1'b0;
        coin_hi    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++; if (credit !== 5'd0) begin n_miss++; $display("FAIL reset_credit: got %0d expected 0", credit); end
        n_vec++; if (can_buy !== 4'b0) begin n_miss++; $display("FAIL reset_can_buy: got %b expected 0000", can_buy); end
        n_vec++; if ({coin_reject, vend_valid, chg_valid, chg_hi} !== 4'b0)
            begin n_miss++; $display("FAIL reset_flags: got %b expected 0000", {coin_reject, vend_valid, chg_valid, chg_hi}); end
        n_vec++; if ({vend_id, vend_count} !== 5'b0)
            begin n_miss++; $display("FAIL reset_id_count: got %0d/%0d expected 0/0", vend_id, vend_count); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_idle_ignore();
        sel_valid = 1'b1; sel_id = 2'd0; refund_req = 1'b1;
        step();
        sel_valid = 1'b0; refund_req = 1'b0;
        n_vec++; if ({vend_valid, chg_valid} !== 2'b00 || credit !== 5'd0)
            begin n_miss++; $display("FAIL idle_ignore: got vv=%b cv=%b credit=%0d expected 0 0 0", vend_valid, chg_valid, credit); end
    endtask

    task automatic test_coins();
        insert_coin(1'b0);
        insert_coin(1'b0);
        insert_coin(1'b1);
        n_vec++; if (credit !== 5'd7) begin n_miss++; $display("FAIL coins_credit: got %0d expected 7", credit); end
        n_vec++; if (can_buy !== 4'b0111) begin n_miss++; $display("FAIL coins_can_buy: got %b expected 0111", can_buy); end
        n_vec++; if (vend_count !== 3'd0) begin n_miss++; $display("FAIL coins_vend_count: got %0d expected 0", vend_count); end
    endtask

    task automatic test_overflow();
        insert_coin(1'b1);
        insert_coin(1'b1);
        insert_coin(1'b0);
        n_vec++; if (credit !== 5'd18) begin n_miss++; $display("FAIL ovf_pre_credit: got %0d expected 18", credit); end
        insert_coin(1'b1);
        n_vec++; if (coin_reject !== 1'b1) begin n_miss++; $display("FAIL ovf_reject: got %b expected 1", coin_reject); end
        n_vec++; if (credit !== 5'd18) begin n_miss++; $display("FAIL ovf_credit_hold: got %0d expected 18", credit); end
        step();
        n_vec++; if (coin_reject !== 1'b0) begin n_miss++; $display("FAIL ovf_reject_pulse: got %b expected 0", coin_reject); end
        insert_coin(1'b0);
        n_vec++; if (credit !== 5'd19 || coin_reject !== 1'b0)
            begin n_miss++; $display("FAIL ovf_lo_accept: got credit=%0d rej=%b expected 19 0", credit, coin_reject); end
    endtask

    // Refund from start_credit; toggle=1 alternates chg_ready starting low.
    task automatic run_refund(input int start_credit, input bit toggle);
        int   c;
        int   cyc;
        logic rdy;
        logic exp_hi;
        c = start_credit;
        while (c >= 1) begin
            exp_chg_q.push_back(c >= 5);
            c = c - ((c >= 5) ? 5 : 1);
        end
        refund_req = 1'b1;
        step();
        refund_req = 1'b0;
        cyc = 0;
        rdy = 1'b1;
        while (exp_chg_q.size() > 0 && cyc < 64) begin
            rdy       = toggle ? ~rdy : 1'b1;
            chg_ready = rdy;
            n_vec++;
            if (chg_valid !== 1'b1) begin
                n_miss++;
                $display("FAIL chg_valid: got %b expected 1 (credit %0d)", chg_valid, credit);
                break;
            end else if (rdy) begin
                exp_hi = exp_chg_q.pop_front();
                if (chg_hi !== exp_hi) begin n_miss++; $display("FAIL chg_coin: got hi=%b expected hi=%b", chg_hi, exp_hi); end
            end else begin
                if (chg_hi !== exp_chg_q[0]) begin n_miss++; $display("FAIL chg_hold: got hi=%b expected hi=%b", chg_hi, exp_chg_q[0]); end
            end
            step();
            cyc++;
        end
        chg_ready = 1'b0;
        n_vec++;
        if (exp_chg_q.size() != 0) begin
            n_miss++;
            $display("FAIL chg_incomplete: got %0d coins outstanding expected 0", exp_chg_q.size());
            exp_chg_q.delete();
        end
        n_vec++; if (credit !== 5'd0 || chg_valid !== 1'b0 || vend_count !== 3'd0)
            begin n_miss++; $display("FAIL chg_end: got credit=%0d cv=%b cnt=%0d expected 0 0 0", credit, chg_valid, vend_count); end
    endtask

    task automatic test_refund_toggle();
        insert_coin(1'b1);
        insert_coin(1'b1);
        insert_coin(1'b0);
        insert_coin(1'b0);
        n_vec++; if (credit !== 5'd12) begin n_miss++; $display("FAIL refund_pre_credit: got %0d expected 12", credit); end
        run_refund(12, 1'b1);
    endtask

`ifndef VEND_AUTO_CHANGE_EN
    task automatic test_vend();
        logic [SEL_W-1:0] exp_id;
        insert_coin(1'b0);
        insert_coin(1'b0);
        insert_coin(1'b1);
        sel_valid = 1'b1; sel_id = 2'd1;
        exp_vend_q.push_back(2'd1);
        step();
        sel_valid = 1'b0;
        n_vec++; if (vend_valid !== 1'b1 || credit !== 5'd2)
            begin n_miss++; $display("FAIL vend_start: got vv=%b credit=%0d expected 1 2", vend_valid, credit); end
        n_vec++; if (can_buy !== 4'b0000) begin n_miss++; $display("FAIL vend_can_buy: got %b expected 0000", can_buy); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (vend_valid !== 1'b1 || vend_id !== exp_vend_q[0])
                begin n_miss++; $display("FAIL vend_hold: got vv=%b id=%0d expected 1 %0d", vend_valid, vend_id, exp_vend_q[0]); end
        end
        vend_ack = 1'b1;
        exp_id = exp_vend_q.pop_front();
        n_vec++; if (vend_id !== exp_id) begin n_miss++; $display("FAIL vend_id: got %0d expected %0d", vend_id, exp_id); end
        step();
        vend_ack = 1'b0;
        n_vec++; if (vend_valid !== 1'b0 || vend_count !== 3'd1 || credit !== 5'd2)
            begin n_miss++; $display("FAIL vend_done: got vv=%b cnt=%0d credit=%0d expected 0 1 2", vend_valid, vend_count, credit); end
        // Unaffordable product is ignored.
        sel_valid = 1'b1; sel_id = 2'd0;
        step();
        sel_valid = 1'b0;
        n_vec++; if (vend_valid !== 1'b0 || credit !== 5'd2)
            begin n_miss++; $display("FAIL vend_insufficient: got vv=%b credit=%0d expected 0 2", vend_valid, credit); end
    endtask

    task automatic test_sel_coin_same_cycle();
        logic [SEL_W-1:0] exp_id;
        insert_coin(1'b0);
        insert_coin(1'b0);
        insert_coin(1'b0);
        n_vec++; if (credit !== 5'd5 || can_buy !== 4'b0011)
            begin n_miss++; $display("FAIL same_pre: got credit=%0d can_buy=%b expected 5 0011", credit, can_buy); end
        coin_valid = 1'b1; coin_hi = 1'b0;
        sel_valid  = 1'b1; sel_id  = 2'd0;
        exp_vend_q.push_back(2'd0);
        step();
        coin_valid = 1'b0; sel_valid = 1'b0;
        n_vec++; if (vend_valid !== 1'b1 || coin_reject !== 1'b1 || credit !== 5'd2)
            begin n_miss++; $display("FAIL same_cycle: got vv=%b rej=%b credit=%0d expected 1 1 2", vend_valid, coin_reject, credit); end
        vend_ack = 1'b1;
        exp_id = exp_vend_q.pop_front();
        n_vec++; if (vend_id !== exp_id) begin n_miss++; $display("FAIL same_vend_id: got %0d expected %0d", vend_id, exp_id); end
        step();
        vend_ack = 1'b0;
        n_vec++; if (vend_count !== 3'd2 || vend_valid !== 1'b0)
            begin n_miss++; $display("FAIL same_count: got cnt=%0d vv=%b expected 2 0", vend_count, vend_valid); end
        run_refund(2, 1'b0);
    endtask

    task automatic test_reset_mid_vend();
        insert_coin(1'b1);
        sel_valid = 1'b1; sel_id = 2'd1;
        step();
        sel_valid = 1'b0;
        n_vec++; if (vend_valid !== 1'b1) begin n_miss++; $display("FAIL rst_vend_pre: got %b expected 1", vend_valid); end
        reset = 1'b1;
        #1;
        n_vec++; if (vend_valid !== 1'b0 || credit !== 5'd0 || vend_count !== 3'd0)
            begin n_miss++; $display("FAIL rst_vend_abort: got vv=%b credit=%0d cnt=%0d expected 0 0 0", vend_valid, credit, vend_count); end
        step();
        reset = 1'b0;
        step();
    endtask
`else
    task automatic test_auto_change();
        logic [SEL_W-1:0] exp_id;
        insert_coin(1'b1);
        for (int i = 0; i < 4; i++) insert_coin(1'b0);
        sel_valid = 1'b1; sel_id = 2'd0;
        exp_vend_q.push_back(2'd0);
        step();
        sel_valid = 1'b0;
        n_vec++; if (credit !== 5'd6 || vend_valid !== 1'b1)
            begin n_miss++; $display("FAIL auto_vend: got credit=%0d vv=%b expected 6 1", credit, vend_valid); end
        vend_ack = 1'b1;
        exp_id = exp_vend_q.pop_front();
        n_vec++; if (vend_id !== exp_id) begin n_miss++; $display("FAIL auto_vend_id: got %0d expected %0d", vend_id, exp_id); end
        step();
        vend_ack = 1'b0;
        n_vec++; if (chg_valid !== 1'b1 || chg_hi !== 1'b1 || vend_count !== 3'd1)
            begin n_miss++; $display("FAIL auto_chg_hi: got cv=%b hi=%b cnt=%0d expected 1 1 1", chg_valid, chg_hi, vend_count); end
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        n_vec++; if (chg_valid !== 1'b1 || chg_hi !== 1'b0 || credit !== 5'd1)
            begin n_miss++; $display("FAIL auto_chg_lo: got cv=%b hi=%b credit=%0d expected 1 0 1", chg_valid, chg_hi, credit); end
        reset = 1'b1;
        #1;
        n_vec++; if ({chg_valid, chg_hi, vend_valid, coin_reject} !== 4'b0 || credit !== 5'd0 || vend_count !== 3'd0 || can_buy !== 4'b0)
            begin n_miss++; $display("FAIL auto_reset_abort: got cv=%b hi=%b credit=%0d cnt=%0d expected all 0", chg_valid, chg_hi, credit, vend_count); end
        step();
        reset = 1'b0;
        step();
    endtask
`endif

    initial begin
        price_bus_t pb;
        pb = '0;
        pb = price_pack(pb, 0, CREDIT_W, 16'd3);
        pb = price_pack(pb, 1, CREDIT_W, 16'd5);
        pb = price_pack(pb, 2, CREDIT_W, 16'd7);
        pb = price_pack(pb, 3, CREDIT_W, 16'd10);
        price      = pb[N_PROD*CREDIT_W-1:0];
        reset      = 1'b1;
        coin_valid = 1'b0; coin_hi   = 1'b0;
        sel_valid  = 1'b0; sel_id    = '0;
        refund_req = 1'b0; vend_ack  = 1'b0;
        chg_ready  = 1'b0;

        test_reset();
        test_idle_ignore();
        test_coins();
        test_overflow();
        run_refund(19, 1'b0);
        test_refund_toggle();
`ifndef VEND_AUTO_CHANGE_EN
        test_vend();
        test_sel_coin_same_cycle();
        test_reset_mid_vend();
`else
        test_auto_change();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
